// File: rtl/spart.sv
// rtl/spart.sv - bus-programmable 8N1 UART with 16x oversampling baud generator
// Single-buffered TX and RX, divisor DB gives one oversample tick every DB+1 clocks.
module spart (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam logic [15:0] DB_RESET = 16'h0516;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    logic [15:0] db;
    logic        wr_tx;
    logic        rd_rx;
    logic        bus_rd_en;
    logic [7:0]  rd_data;

    assign wr_tx     = iocs && !iorw && (ioaddr == 2'b00) && tbr;
    assign rd_rx     = iocs && iorw && (ioaddr == 2'b00);
    assign bus_rd_en = iocs && iorw && !ioaddr[1];

    // ------------------------------------------------------------------
    // Divisor register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            db <= DB_RESET;
        end else if (iocs && !iorw) begin
            if (ioaddr == 2'b10) db[7:0]  <= databus;
            if (ioaddr == 2'b11) db[15:8] <= databus;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t      tx_state, tx_state_nx;
    logic [15:0] tx_cnt, tx_cnt_nx;
    logic [3:0]  tx_ticks, tx_ticks_nx;
    logic [2:0]  tx_idx, tx_idx_nx;
    logic [7:0]  tx_shift, tx_shift_nx;
    logic        txd_nx, tbr_nx;
    logic        tx_tick, tx_bit_end;

    assign tx_tick    = (tx_state != ST_IDLE) && (tx_cnt == 16'd0);
    assign tx_bit_end = tx_tick && (tx_ticks == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= DB_RESET;
            tx_ticks <= 4'd0;
            tx_idx   <= 3'd0;
            tx_shift <= 8'd0;
            txd      <= 1'b1;
            tbr      <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_ticks <= tx_ticks_nx;
            tx_idx   <= tx_idx_nx;
            tx_shift <= tx_shift_nx;
            txd      <= txd_nx;
            tbr      <= tbr_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_ticks_nx = tx_ticks;
        tx_idx_nx   = tx_idx;
        tx_shift_nx = tx_shift;
        txd_nx      = txd;
        tbr_nx      = tbr;

        if (tx_state != ST_IDLE) begin
            tx_cnt_nx = tx_tick ? db : tx_cnt - 16'd1;
        end
        if (tx_tick) begin
            tx_ticks_nx = tx_ticks + 4'd1;
        end

        case (tx_state)
            ST_IDLE: begin
                if (wr_tx) begin
                    tx_state_nx = ST_START;
                    tx_shift_nx = databus;
                    tx_cnt_nx   = db;
                    tx_ticks_nx = 4'd0;
                    tx_idx_nx   = 3'd0;
                    txd_nx      = 1'b0;
                    tbr_nx      = 1'b0;
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_state_nx = ST_DATA;
                    txd_nx      = tx_shift[0];
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == 3'd7) begin
                        tx_state_nx = ST_STOP;
                        txd_nx      = 1'b1;
                    end else begin
                        tx_idx_nx   = tx_idx + 3'd1;
                        tx_shift_nx = {1'b0, tx_shift[7:1]};
                        txd_nx      = tx_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_bit_end) begin
                    tx_state_nx = ST_IDLE;
                    tbr_nx      = 1'b1;
                end
            end
            default: tx_state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic        rxd_meta, rxd_sync;
    state_t      rx_state, rx_state_nx;
    logic [15:0] rx_cnt, rx_cnt_nx;
    logic [3:0]  rx_ticks, rx_ticks_nx;
    logic [2:0]  rx_idx, rx_idx_nx;
    logic [7:0]  rx_shift, rx_shift_nx;
    logic [7:0]  rx_buf, rx_buf_nx;
    logic        rda_nx;
    logic        rx_tick, rx_bit_end;

    assign rx_tick    = (rx_state != ST_IDLE) && (rx_cnt == 16'd0);
    assign rx_bit_end = rx_tick && (rx_ticks == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= DB_RESET;
            rx_ticks <= 4'd0;
            rx_idx   <= 3'd0;
            rx_shift <= 8'd0;
            rx_buf   <= 8'd0;
            rda      <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_ticks <= rx_ticks_nx;
            rx_idx   <= rx_idx_nx;
            rx_shift <= rx_shift_nx;
            rx_buf   <= rx_buf_nx;
            rda      <= rda_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_ticks_nx = rx_ticks;
        rx_idx_nx   = rx_idx;
        rx_shift_nx = rx_shift;
        rx_buf_nx   = rx_buf;
        rda_nx      = rda;

        if (rx_state != ST_IDLE) begin
            rx_cnt_nx = rx_tick ? db : rx_cnt - 16'd1;
        end
        if (rx_tick) begin
            rx_ticks_nx = rx_ticks + 4'd1;
        end
        // A completing frame below overrides this clear (set wins).
        if (rd_rx) begin
            rda_nx = 1'b0;
        end

        case (rx_state)
            ST_IDLE: begin
                if (!rxd_sync) begin
                    rx_state_nx = ST_START;
                    rx_cnt_nx   = db;
                    rx_ticks_nx = 4'd0;
                    rx_idx_nx   = 3'd0;
                end
            end
            ST_START: begin
                // Mid start bit; restarting the tick phase aligns data samples to bit centres.
                if (rx_tick && (rx_ticks == 4'd7)) begin
                    rx_ticks_nx = 4'd0;
                    rx_state_nx = rxd_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_nx = {rxd_sync, rx_shift[7:1]};
                    rx_idx_nx   = rx_idx + 3'd1;
                    if (rx_idx == 3'd7) begin
                        rx_state_nx = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (rx_bit_end) begin
                    rx_state_nx = ST_IDLE;
                    if (rxd_sync) begin
                        rx_buf_nx = rx_shift;
                        rda_nx    = 1'b1;
                    end
                end
            end
            default: rx_state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus read path
    // ------------------------------------------------------------------
    assign rd_data = ioaddr[0] ? {6'b0, tbr, rda} : rx_buf;
    assign databus = bus_rd_en ? rd_data : 8'bz;

endmodule

// File: doc/spart.md
# spart

Special-purpose asynchronous receiver/transmitter. It connects the processor-side bus master (iocs/iorw/ioaddr/databus) to a serial 8N1 line pair (txd/rxd). It contains a programmable 16x-oversampling baud generator, a single-buffered transmitter and a single-buffered receiver. The bus master programs the divisor, polls `tbr`/`rda`, reads received bytes and writes bytes for transmission.

## Interface
- No parameters. The divisor is a runtime value written over the bus.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `iocs`  in  1  chip select; a bus access happens only when high.
- `iorw`  in  1  1 = read, 0 = write.
- `ioaddr`  in  2  register select:
  - 00: TX buffer on write, RX buffer on read.
  - 01: status, read-only, value {6'b0, tbr, rda}.
  - 10: divisor low byte, write-only.
  - 11: divisor high byte, write-only.
- `databus`  inout  8  bidirectional data bus.
- `rda`  out  1  receive data available.
- `tbr`  out  1  transmit buffer ready; a write to 00 is accepted only when `tbr` is high.
- `txd`  out  1  serial out, idles high.
- `rxd`  in  1  serial in, asynchronous, idles high.

## Operation
**Bus read path**
- `databus` is driven only when iocs=1 and iorw=1 and ioaddr is 00 or 01.
- Otherwise `databus` is 8'bz.
- Read data is combinational from registers, so the master can capture it at the same edge.

**Divisor register DB[15:0]**
- A write to 10 loads DB[7:0]; a write to 11 loads DB[15:8].
- Reset value is 16'h0516 (4800 baud at 100 MHz).
- Oversample tick period is DB+1 clocks. DB=0 gives a tick every cycle.

**Tick counters**
- Two independent down-counters: one for TX, one for RX.
- Each counter pulses its tick when it reaches 0, then reloads DB.
- A bit time is 16 ticks = 16*(DB+1) clocks.
- The TX counter reloads DB when a byte is loaded. The RX counter reloads DB on start detection.
- A DB write takes effect at the next reload. A frame already in flight is not restarted.

**Transmitter**
- FSM states: IDLE, START, DATA, STOP.
- A write to 00 while tbr=1 loads the shift register from `databus`. At that edge tbr goes to 0, txd goes to 0 and the FSM enters START.
- Each state lasts 16 TX ticks.
- DATA sends 8 bits LSB first, with a bit index 0..7.
- STOP drives txd=1. After its 16th tick, tbr returns to 1 and the FSM goes to IDLE.
- A write to 00 while tbr=0 is ignored: no data corruption, no restart.

**Receiver**
- rxd passes through a 2-flop synchronizer.
- FSM states: IDLE, START, DATA, STOP.
- In IDLE, a synchronized low starts the RX counter and moves to START.
- At the 8th tick (mid start bit):
  - synchronized rxd still low: go to DATA;
  - otherwise (false start): back to IDLE, no other effect.
- In DATA, sample every 16 ticks, 8 samples, LSB first.
- In STOP, sample 16 ticks after the last data sample:
  - rxd=1: load RX buffer and set rda=1;
  - rxd=0 (framing error): discard the byte, rda unchanged, RX buffer unchanged.
  - In both cases return to IDLE.
- Reading 00 with iocs=1, iorw=1 clears rda at that edge.

**Boundary cases**
- Overrun (new byte completes while rda=1): the new byte overwrites the RX buffer and rda stays 1.
- Read of 00 in the same cycle a byte completes: set wins, so rda=1 with the new byte.
- Writes to 01 are ignored.
- Reads of 10/11 leave `databus` at Z.

## Timing
- Reset values:
  - txd=1, tbr=1, rda=0, `databus` Z;
  - both FSMs IDLE, DB=16'h0516;
  - both counters = DB, shift registers 0, RX buffer 0.
- `rst` mid-frame aborts both directions. At the next edge txd=1 and tbr=1, and any partial RX byte is lost.
- TX latency: txd falls at the same edge the write is sampled. A frame is 10 bit times, i.e. 160*(DB+1) clocks from write to tbr=1.
- RX latency: rda rises 2–3 clocks (synchronizer plus detect) plus 152*(DB+1) clocks after the rxd falling edge.
- Status and RX data reads have zero wait states. Captured data is valid at the edge where iocs=1.

## Test plan
1. Reset, then read 01 → `databus`=8'h02, read 00 → 8'h00, txd=1, rda=0, and `databus`=Z when iocs=0.
2. Write 10←8'h03, 11←8'h00, 00←8'hA5 → txd shows 0,1,0,1,0,0,1,0,1,1, each bit held 64 clocks. tbr is 0 for 640 clocks then 1. A second write 00←8'hFF during the frame is ignored.
3. DB=3, drive rxd with frame 8'h3C at 64 clocks/bit → rda=1 about 2+608 clocks after the start edge. Read 00 → 8'h3C and rda=0 next cycle.
4. DB=3, rxd low for 20 clocks then high → rda stays 0 and the RX FSM returns to IDLE. A valid 8'h81 frame sent afterwards is received correctly.
5. DB=3, frame 8'h55 with stop bit 0 → rda stays 0 and the RX buffer keeps its prior value. Then send two good frames 8'h11 and 8'h22 without reading → read returns 8'h22 and rda=1 until that read.
6. Loopback txd→rxd with DB=16'h00A2: write 00←8'h5A → rda rises, read 00 → 8'h5A. Assert rst mid-frame → txd=1, tbr=1, rda=0 at the next edge.
